// File: rtl/id_operand_stage.sv
// Decode and operand-fetch stage feeding the 32-bit ALU.
// Holds the 32x32 register file, decodes R-type and immediate forms and
// presents operands through a one-entry valid/ready output register.
module id_operand_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter bit          HARDWIRE_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_cs,
  output logic [4:0]        dest_addr,
  output logic              illegal
);

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CSW  = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [CSW-1:0]    alu_cs_q, alu_cs_d;
  logic [AW-1:0]     dest_addr_q, dest_addr_d;
  logic              illegal_q, illegal_d;

  logic [5:0]        op, funct;
  logic [AW-1:0]     rs, rt, rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [DATA_W-1:0] dec_a, dec_b;
  logic [CSW-1:0]    dec_cs;
  logic [AW-1:0]     dec_dest;
  logic              dec_illegal;
  logic              accept;
  logic              unused_shamt;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign imm   = instr[15:0];
  assign funct = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Register-file write port; index 0 is dropped when hardwired.
  always_comb begin
    regs_d = regs_q;
    if (wb_en && !(HARDWIRE_R0 && (wb_addr == AW'(0)))) begin
      regs_d[wb_addr] = wb_data;
    end
  end

  // Register-file storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports with same-cycle write-back bypass.
  always_comb begin
    rs_val = regs_q[rs];
    if (wb_en && (wb_addr == rs) && (rs != AW'(0))) begin
      rs_val = wb_data;
    end
    if (HARDWIRE_R0 && (rs == AW'(0))) begin
      rs_val = '0;
    end
    rt_val = regs_q[rt];
    if (wb_en && (wb_addr == rt) && (rt != AW'(0))) begin
      rt_val = wb_data;
    end
    if (HARDWIRE_R0 && (rt == AW'(0))) begin
      rt_val = '0;
    end
  end

  // Instruction decode; unsupported encodings collapse to an all-zero illegal bundle.
  always_comb begin
    dec_illegal = 1'b1;
    dec_cs      = '0;
    dec_a       = '0;
    dec_b       = '0;
    dec_dest    = '0;
    case (op)
      OP_RTYPE: begin
        if ((funct == FN_AND) || (funct == FN_OR) || (funct == FN_ADD) ||
            (funct == FN_SUB) || (funct == FN_MULT)) begin
          dec_illegal = 1'b0;
          dec_cs      = funct;
          dec_a       = rs_val;
          dec_b       = rt_val;
          dec_dest    = rd;
        end
      end
      OP_ADDI: begin
        dec_illegal = 1'b0;
        dec_cs      = FN_ADD;
        dec_a       = rs_val;
        dec_b       = {{(DATA_W-16){imm[15]}}, imm};
        dec_dest    = rt;
      end
      OP_ANDI: begin
        dec_illegal = 1'b0;
        dec_cs      = FN_AND;
        dec_a       = rs_val;
        dec_b       = DATA_W'(imm);
        dec_dest    = rt;
      end
      OP_ORI: begin
        dec_illegal = 1'b0;
        dec_cs      = FN_OR;
        dec_a       = rs_val;
        dec_b       = DATA_W'(imm);
        dec_dest    = rt;
      end
      default: ;
    endcase
  end

  // Output register next-state: load on accept, drain on consume, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cs_d    = alu_cs_q;
    dest_addr_d = dest_addr_q;
    illegal_d   = illegal_q;
    if (accept) begin
      out_valid_d = 1'b1;
      alu_a_d     = dec_a;
      alu_b_d     = dec_b;
      alu_cs_d    = dec_cs;
      dest_addr_d = dec_dest;
      illegal_d   = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cs_q    <= '0;
      dest_addr_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cs_q    <= alu_cs_d;
      dest_addr_q <= dest_addr_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cs    = alu_cs_q;
  assign dest_addr = dest_addr_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: a reference decoder and register
// model push expected bundles on accept; they are compared as they drain.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_cs;
  logic [4:0]  dest_addr;
  logic        illegal;

  id_operand_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cs    (alu_cs),
    .dest_addr (dest_addr),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  cs;
    logic [4:0]  dest;
    logic        ill;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mregs [32];
  logic        exp_ov;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference register read including same-cycle bypass; R0 is always zero.
  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && (wb_addr == idx)) return wb_data;
    return mregs[idx];
  endfunction

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    e = '{a: 32'd0, b: 32'd0, cs: 6'd0, dest: 5'd0, ill: 1'b1};
    if (op == 6'b000000) begin
      if (fn == 6'b100100 || fn == 6'b100101 || fn == 6'b100000 ||
          fn == 6'b100010 || fn == 6'b011000) begin
        e = '{a: mread(ins[25:21]), b: mread(ins[20:16]), cs: fn, dest: ins[15:11], ill: 1'b0};
      end
    end else if (op == 6'b001000) begin
      e = '{a: mread(ins[25:21]), b: {{16{ins[15]}}, ins[15:0]}, cs: 6'b100000,
            dest: ins[20:16], ill: 1'b0};
    end else if (op == 6'b001100) begin
      e = '{a: mread(ins[25:21]), b: {16'h0000, ins[15:0]}, cs: 6'b100100,
            dest: ins[20:16], ill: 1'b0};
    end else if (op == 6'b001101) begin
      e = '{a: mread(ins[25:21]), b: {16'h0000, ins[15:0]}, cs: 6'b100101,
            dest: ins[20:16], ill: 1'b0};
    end
    return e;
  endfunction

  // One clock: called at a falling edge with inputs already applied; checks
  // outputs, updates the model for the coming rising edge, returns at the next falling edge.
  task automatic cycle();
    exp_t e;
    logic acc;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!exp_ov || out_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq[0];
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("alu_cs", 32'(alu_cs), 32'(e.cs));
        chk("dest_addr", 32'(dest_addr), 32'(e.dest));
        chk("illegal", 32'(illegal), 32'(e.ill));
        if (out_ready) void'(sbq.pop_front());
      end
    end
    acc = in_valid && (!exp_ov || out_ready);
    if (acc) sbq.push_back(model(instr));
    if (acc) exp_ov = 1'b1;
    else if (out_ready) exp_ov = 1'b0;
    if (wb_en && (wb_addr != 5'd0)) mregs[wb_addr] = wb_data;
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic wbe,
                       input logic [4:0] wba, input logic [31:0] wbd, input logic ordy);
    in_valid  = iv;
    instr     = ins;
    wb_en     = wbe;
    wb_addr   = wba;
    wb_data   = wbd;
    out_ready = ordy;
    cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_ov; i++) drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("drain_empty", 32'(exp_ov), 32'd0);
  endtask

  task automatic model_reset();
    sbq.delete();
    exp_ov = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
  endtask

  logic [31:0] rin;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; wb_en = 1'b0;
    wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_cs", 32'(alu_cs), 32'd0);
    rst_n = 1'b1;

    // Register loads and R-type operand fetch.
    drive(1'b0, 32'd0, 1'b1, 5'd1, 32'd30, 1'b1);
    drive(1'b0, 32'd0, 1'b1, 5'd2, 32'd25, 1'b1);
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'b100000), 1'b0, 5'd0, 32'd0, 1'b1);
    chk("add_a", alu_a, 32'd30);
    chk("add_b", alu_b, 32'd25);
    chk("add_cs", 32'(alu_cs), 32'h20);
    chk("add_dest", 32'(dest_addr), 32'd3);
    drive(1'b1, rtype(5'd1, 5'd2, 5'd6, 6'b011000), 1'b0, 5'd0, 32'd0, 1'b1);
    chk("mult_cs", 32'(alu_cs), 32'h18);

    // Immediate sign/zero extension.
    drive(1'b1, itype(6'b001000, 5'd1, 5'd4, 16'hFFFF), 1'b0, 5'd0, 32'd0, 1'b1);
    chk("addi_b", alu_b, 32'hFFFFFFFF);
    chk("addi_dest", 32'(dest_addr), 32'd4);
    drive(1'b1, itype(6'b001101, 5'd1, 5'd4, 16'hFFFF), 1'b0, 5'd0, 32'd0, 1'b1);
    chk("ori_b", alu_b, 32'h0000FFFF);
    chk("ori_cs", 32'(alu_cs), 32'h25);

    // Same-cycle bypass and hardwired R0.
    drive(1'b1, rtype(5'd5, 5'd0, 5'd9, 6'b100010), 1'b1, 5'd5, 32'd7, 1'b1);
    chk("byp_a", alu_a, 32'd7);
    chk("byp_b", alu_b, 32'd0);
    chk("byp_cs", 32'(alu_cs), 32'h22);
    drive(1'b0, 32'd0, 1'b1, 5'd0, 32'd99, 1'b1);
    drive(1'b1, rtype(5'd0, 5'd0, 5'd8, 6'b100101), 1'b1, 5'd0, 32'd99, 1'b1);
    chk("r0_a", alu_a, 32'd0);

    // Illegal encodings pass through as zeroed bundles.
    drive(1'b1, itype(6'b100011, 5'd1, 5'd2, 16'h1234), 1'b0, 5'd0, 32'd0, 1'b1);
    chk("lw_illegal", 32'(illegal), 32'd1);
    chk("lw_a", alu_a, 32'd0);
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'b101010), 1'b0, 5'd0, 32'd0, 1'b1);
    chk("slt_illegal", 32'(illegal), 32'd1);
    chk("slt_dest", 32'(dest_addr), 32'd0);
    drain();

    // Backpressure: hold the first bundle while write-back hits its rs register.
    drive(1'b1, rtype(5'd1, 5'd2, 5'd7, 6'b100000), 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, rtype(5'd1, 5'd5, 5'd10, 6'b100101), 1'b1, 5'd1, 32'd555, 1'b0);
    chk("hold_a", alu_a, 32'd30);
    drive(1'b1, rtype(5'd1, 5'd5, 5'd10, 6'b100101), 1'b0, 5'd0, 32'd0, 1'b1);
    drive(1'b1, itype(6'b001100, 5'd1, 5'd11, 16'h00F0), 1'b0, 5'd0, 32'd0, 1'b1);
    drive(1'b1, rtype(5'd2, 5'd1, 5'd12, 6'b100010), 1'b0, 5'd0, 32'd0, 1'b1);
    drain();

    // Randomised traffic with random backpressure and write-back.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: rin = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'b100000);
        1: rin = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'b100010);
        2: rin = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'b100100);
        3: rin = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'b011000);
        4: rin = itype(6'b001000, 5'($urandom), 5'($urandom), 16'($urandom));
        5: rin = itype(6'b001100, 5'($urandom), 5'($urandom), 16'($urandom));
        6: rin = itype(6'b001101, 5'($urandom), 5'($urandom), 16'($urandom));
        default: rin = $urandom;
      endcase
      drive(1'($urandom), rin, 1'($urandom), 5'($urandom), $urandom, 1'($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset while an output is held.
    drain();
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'b100000), 1'b0, 5'd0, 32'd0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_alu_b", alu_b, 32'd0);
    chk("arst_dest", 32'(dest_addr), 32'd0);
    in_valid = 1'b0;
    wb_en = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // Every register must read back zero after reset.
    for (int k = 0; k < 16; k++)
      drive(1'b1, rtype(5'(2 * k), 5'(2 * k + 1), 5'(k), 6'b100101), 1'b0, 5'd0, 32'd0, 1'b1);
    drain();
    chk("sb_final_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode and operand-fetch stage directly upstream of the 32-bit ALU.
- Holds the 32x32 register file and decodes R-type and immediate instructions into the ALU control code (alu_cs) and operands A/B.
- Delivers them through a one-entry valid/ready output register.
- Accepts write-back from the downstream stage, with same-cycle bypass.

Parameters:
- DATA_W, 32, operand/register width; only 32 is supported.
- HARDWIRE_R0, 1, when 1, register 0 reads as 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instr is presented
- in_ready  output  1  stage can accept instr this cycle
- instr  input  32  MIPS instruction word
- wb_en  input  1  register write enable from write-back
- wb_addr  input  5  write-back register index
- wb_data  input  32  write-back data
- out_valid  output  1  alu_a/alu_b/alu_cs/dest_addr/illegal valid
- out_ready  input  1  ALU side consumes output this cycle
- alu_a  output  32  ALU operand A
- alu_b  output  32  ALU operand B
- alu_cs  output  6  ALU control code
- dest_addr  output  5  destination register index for write-back
- illegal  output  1  instruction not in supported set

Behaviour:
- Reset (rst_n low, asynchronous):
  - All 32 registers cleared to 0.
  - out_valid=0, alu_a=0, alu_b=0, alu_cs=6'b000000, dest_addr=0, illegal=0.
- Reset mid-transaction discards the held output. in_ready is 1 on the first cycle after reset release.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept, the output register loads the decoded values at the next rising edge and out_valid=1.
  - If out_valid && out_ready && !accept, out_valid goes to 0 at the next edge.
  - While out_valid && !out_ready, all outputs hold bit-stable. Later write-backs do NOT update held operands.
- Latency: 1 cycle from accept to out_valid; full throughput of one instruction per cycle when out_ready is held high.
- Fields: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], funct=[5:0].
- Decode, op=000000 (R-type):
  - Legal only when funct is in {100100 AND, 100101 OR, 100000 ADD, 100010 SUB, 011000 MULT}.
  - alu_cs=funct, alu_a=R[rs], alu_b=R[rt], dest_addr=rd.
  - MULT result goes to rd; there is no HI/LO.
- Decode, op=001000 (ADDI): alu_cs=100000, alu_b=sign-extended imm, dest_addr=rt.
- Decode, op=001100 (ANDI): alu_cs=100100, alu_b=zero-extended imm, dest_addr=rt.
- Decode, op=001101 (ORI): alu_cs=100101, alu_b=zero-extended imm, dest_addr=rt.
- Immediate forms use alu_a=R[rs].
- Any other op, or an R-type with another funct: illegal=1, alu_cs=000000, alu_a=0, alu_b=0, dest_addr=0. It is still accepted and passed with out_valid=1.
- Register file:
  - Write at the rising edge when wb_en=1.
  - Writes to index 0 are dropped when HARDWIRE_R0=1.
  - Reads are combinational.
- Bypass: when wb_en=1, wb_addr equals the read index, and the index is nonzero, the read returns wb_data in the same cycle as the accept. This applies independently to rs and rt.
- Write-back and accept in the same cycle are legal and independent. Write-back is accepted regardless of out_valid/out_ready.
- Register 0 always reads 0, including under bypass, when HARDWIRE_R0=1.

Test Plan:
- Reset: assert rst_n=0 mid-run with out_valid=1 -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and every register reads 0.
- Load and R-type: write R1=30, R2=25 via wb, then ADD rd=3, rs=1, rt=2 (funct 100000) -> next cycle alu_a=30, alu_b=25, alu_cs=100000, dest_addr=3. With MULT funct -> alu_cs=011000.
- Immediates:
  - ADDI rt=4, rs=1, imm=0xFFFF -> alu_b=0xFFFFFFFF, alu_cs=100000, dest_addr=4.
  - ORI with same imm -> alu_b=0x0000FFFF, alu_cs=100101.
- Bypass and R0:
  - wb_en=1, wb_addr=5, wb_data=7 in the same cycle as accepting SUB rs=5, rt=0 -> alu_a=7, alu_b=0, alu_cs=100010.
  - Write 99 to R0 -> R0 still reads 0.
- Backpressure: out_ready=0 with in_valid=1 for 3 cycles -> first instr held stable, in_ready=0 and a later wb to the rs register does not alter alu_a. Raise out_ready -> back-to-back transfer, one per cycle, no loss or duplication.
- Illegal: op=100011 (LW) or R-type funct 101010 -> illegal=1, alu_cs=000000, alu_a=alu_b=0, dest_addr=0, out_valid=1 for one cycle with out_ready=1.
